decryption_ctrl: RTL

DECRYPTION_CTRL -- requirements
Module: decryption_ctrl

---
 rtl/decryption_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/decryption_ctrl.sv
// Packet-aware controller in front of the decryption datapath: marks payload words and
// swaps in new keys only between packets. Optional statistics: define DEC_CTRL_STATS_EN.
module decryption_ctrl #(
    parameter int unsigned HDR_WORDS = 5,
    parameter int unsigned DRAIN_CYC = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [63:0] up_data,
    input  logic [7:0]  up_ctrl,
    input  logic        up_wr,
    output logic        up_rdy,
    output logic [63:0] dp_data,
    output logic [7:0]  dp_ctrl,
    output logic        dp_wr,
    input  logic        dp_rdy,
    output logic        inside_payload,
    input  logic        key_wr,
    input  logic [79:0] key_wdata,
    output logic [79:0] key,
    output logic        key_pending,
    output logic [31:0] pkt_cnt,
    output logic [31:0] pay_cnt
);
    localparam logic [7:0] HdrWords = 8'(HDR_WORDS);
    localparam logic [3:0] DrainCyc = 4'(DRAIN_CYC);

    typedef enum logic [1:0] {StIdle, StModHdr, StBody, StPayload} state_e;

    state_e      r_state;
    logic [7:0]  r_body_cnt;
    logic [3:0]  r_idle_cnt;
    logic [79:0] r_key;
    logic [79:0] r_pending_key;
    logic        r_key_pending;

    logic        w_accept;
    logic        w_ctrl_nz;
    logic        w_apply;

    // Hold off new packets while a key waits, so the drain window can complete.
    assign up_rdy         = dp_rdy && !((r_state == StIdle) && r_key_pending);
    assign w_accept       = up_wr && up_rdy;
    assign w_ctrl_nz      = (up_ctrl != 8'd0);
    assign w_apply        = (r_state == StIdle) && r_key_pending && (r_idle_cnt == DrainCyc);

    assign dp_data        = up_data;
    assign dp_ctrl        = up_ctrl;
    assign dp_wr          = w_accept;
    assign inside_payload = (r_state == StPayload);
    assign key            = r_key;
    assign key_pending    = r_key_pending;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= StIdle;
            r_body_cnt <= 8'd0;
        end else if (w_accept) begin
            unique case (r_state)
                StIdle, StModHdr: begin
                    if (w_ctrl_nz) begin
                        r_state <= StModHdr;
                    end else begin
                        r_body_cnt <= 8'd1;
                        r_state    <= (HdrWords == 8'd1) ? StPayload : StBody;
                    end
                end
                StBody: begin
                    if (w_ctrl_nz) begin
                        r_state <= StIdle;
                    end else begin
                        r_body_cnt <= r_body_cnt + 8'd1;
                        if (r_body_cnt + 8'd1 == HdrWords) r_state <= StPayload;
                    end
                end
                StPayload: begin
                    if (w_ctrl_nz) r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idle_cnt <= DrainCyc;
        end else if (w_accept) begin
            r_idle_cnt <= 4'd0;
        end else if (r_idle_cnt != DrainCyc) begin
            r_idle_cnt <= r_idle_cnt + 4'd1;
        end
    end

    // A key_wr landing in the apply cycle becomes the next pending key.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_key         <= '0;
            r_pending_key <= '0;
            r_key_pending <= 1'b0;
        end else begin
            if (w_apply) begin
                r_key         <= r_pending_key;
                r_key_pending <= key_wr;
            end else if (key_wr) begin
                r_key_pending <= 1'b1;
            end
            if (key_wr) r_pending_key <= key_wdata;
        end
    end

`ifdef DEC_CTRL_STATS_EN
    logic [31:0] r_pkt_cnt;
    logic [31:0] r_pay_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pkt_cnt <= 32'd0;
            r_pay_cnt <= 32'd0;
        end else if (w_accept) begin
            if (w_ctrl_nz && ((r_state == StBody) || (r_state == StPayload))) begin
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
            if (r_state == StPayload) r_pay_cnt <= r_pay_cnt + 32'd1;
        end
    end

    assign pkt_cnt = r_pkt_cnt;
    assign pay_cnt = r_pay_cnt;
`else
    assign pkt_cnt = 32'd0;
    assign pay_cnt = 32'd0;
`endif

endmodule
